waveform_sequencer: RTL



---
 rtl/waveform_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/waveform_sequencer.sv
// waveform_sequencer: 16x8 pattern memory serialised LSB-first by a
// start/stop FSM over a wrapping address window. Option: WAVE_SEQ_LOOP_EN.
module waveform_sequencer (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] first_addr,
  input  logic [3:0] last_addr,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  output logic       wave_out,
  output logic       wave_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] cur_addr,
  output logic [2:0] bit_idx
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  state_e     state_q;
  logic [7:0] mem_q [16];
  logic [7:0] word_q;
  logic [3:0] addr_q;
  logic [3:0] first_q;
  logic [3:0] last_q;
  logic [2:0] bit_q;
  logic       stop_pend_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;

  logic       loop_eff;
  logic       stop_d;
  logic       at_last;
  logic       word_end;
  logic       go;
  logic [3:0] next_addr_d;

  assign go = (state_q == IDLE) && start && !stop;

`ifdef WAVE_SEQ_LOOP_EN
  logic loop_q;

  // Capture the repeat request together with the window.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      loop_q <= 1'b0;
    end else if (go) begin
      loop_q <= loop;
    end
  end

  assign loop_eff = loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_eff    = 1'b0;
`endif

  assign stop_d      = stop_pend_q | stop;
  assign at_last     = (addr_q == last_q);
  assign word_end    = (bit_q == 3'd7);
  assign next_addr_d = at_last ? first_q : addr_q + 4'd1;

  // Pattern memory: writes in any state, reset restores the default pattern.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= i[0] ? 8'hAA : 8'hCC;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      word_q      <= 8'h00;
      addr_q      <= 4'd0;
      first_q     <= 4'd0;
      last_q      <= 4'd0;
      bit_q       <= 3'd0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            first_q <= first_addr;
            last_q  <= last_addr;
            addr_q  <= first_addr;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (stop) stop_pend_q <= 1'b1;
          word_q  <= mem_q[addr_q];
          bit_q   <= 3'd0;
          valid_q <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (stop) stop_pend_q <= 1'b1;
          if (!word_end) begin
            bit_q <= bit_q + 3'd1;
          end else if (stop_d || (at_last && !loop_eff)) begin
            bit_q   <= 3'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q <= next_addr_d;
            word_q <= mem_q[next_addr_d];
            bit_q  <= 3'd0;
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          stop_pend_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wave_out   = valid_q & word_q[bit_q];
  assign wave_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_addr   = addr_q;
  assign bit_idx    = bit_q;

endmodule
